// File: rtl/tl_pkg.sv
// Shared definitions for the left-turn traffic light controller.
//   state_t  : the eight controller states S0..S7 (even = green, odd = yellow)
//   lamp_t   : lamp drive codes GREEN / YELLOW / RED
//   is_legal : a next-state request may only stay put or advance by one (mod 8)
package tl_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // A straight green
        S1 = 3'd1,  // A straight yellow
        S2 = 3'd2,  // A left green
        S3 = 3'd3,  // A left yellow
        S4 = 3'd4,  // B straight green
        S5 = 3'd5,  // B straight yellow
        S6 = 3'd6,  // B left green
        S7 = 3'd7   // B left yellow
    } state_t;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } lamp_t;

    // 3-bit add wraps S7 -> S0 naturally.
    function automatic logic is_legal(input logic [2:0] cs, input logic [2:0] ns);
        logic [2:0] nxt;
        nxt = cs + 3'd1;
        return (ns == cs) || (ns == nxt);
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Tick-based dwell counter for one light state.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clr        : restart the dwell (state change)
//   tick       : count enable, one per timebase tick
//   lim        : dwell limit in ticks for the current state (>=1)
//   cnt        : ticks counted so far, saturating at lim-1
//   done       : cnt has reached lim-1 (minimum dwell satisfied)
module tl_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W:0]   lim,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W:0]   lim_m1_w;
    logic [CNT_W-1:0] lim_m1;

    // lim may equal 2**CNT_W, so it carries one extra bit; lim-1 always fits.
    assign lim_m1_w = lim - 1'b1;
    assign lim_m1   = lim_m1_w[CNT_W-1:0];
    assign done     = (cnt == lim_m1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            // Saturate so a green held past its minimum stays "done".
            if (cnt >= lim_m1) cnt <= lim_m1;
            else               cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tl_state_seq.sv
// State register and lamp driver for the left-turn traffic light controller.
// Closes the cs -> ns_logic -> ns loop: a requested state change is only
// committed once the current state has dwelt long enough, and illegal
// requests are refused and flagged.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   tick              : 1-cycle timebase strobe; dwell is measured in ticks
//   ns                : next-state request from ns_logic
//   cs                : registered current state, back to ns_logic
//   La, Lal, Lb, Lbl  : A straight, A left, B straight, B left lamps
//   err               : sticky flag, set by any illegal ns, cleared by reset
module tl_state_seq
    import tl_pkg::*;
#(
    parameter int YELLOW_TICKS    = 3,
    parameter int GREEN_MIN_TICKS = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] ns,
    output logic [2:0] cs,
    output logic [1:0] La,
    output logic [1:0] Lal,
    output logic [1:0] Lb,
    output logic [1:0] Lbl,
    output logic       err
);

    localparam logic [CNT_W:0] LIM_Y = (CNT_W+1)'(YELLOW_TICKS);
    localparam logic [CNT_W:0] LIM_G = (CNT_W+1)'(GREEN_MIN_TICKS);

    state_t           cs_q, cs_d;
    logic             legal;
    logic             commit;
    logic             done;
    logic [CNT_W:0]   lim;
    logic [CNT_W-1:0] cnt;

    assign legal = is_legal(cs_q, ns);
    // Odd states are yellow: exact dwell. Even states are green: minimum dwell.
    assign lim    = cs_q[0] ? LIM_Y : LIM_G;
    assign commit = tick && legal && done && (ns != cs_q);

    // Illegal requests freeze the counter as well as the state.
    tl_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (commit),
        .tick  (tick && legal),
        .lim   (lim),
        .cnt   (cnt),
        .done  (done)
    );

    always_comb begin
        cs_d = cs_q;
        if (commit) cs_d = state_t'(ns);
    end

    always_ff @(posedge clk) begin
        if (reset) cs_q <= S0;
        else       cs_q <= cs_d;
    end

    always_ff @(posedge clk) begin
        if (reset)       err <= 1'b0;
        else if (!legal) err <= 1'b1;
    end

    assign cs = cs_q;

    // Exactly one lamp is lit in every state; everything else is red.
    always_comb begin
        La  = RED;
        Lal = RED;
        Lb  = RED;
        Lbl = RED;
        case (cs_q)
            S0: La  = GREEN;
            S1: La  = YELLOW;
            S2: Lal = GREEN;
            S3: Lal = YELLOW;
            S4: Lb  = GREEN;
            S5: Lb  = YELLOW;
            S6: Lbl = GREEN;
            S7: Lbl = YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tl_state_seq.sv
// Self-checking bench for tl_state_seq (YELLOW_TICKS=3, GREEN_MIN_TICKS=4,
// tick every 2 clocks). A state/dwell model checks every cycle; directed
// scenarios add literal expectations.
module tb_tl_state_seq;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [2:0] ns;
    logic [2:0] cs;
    logic [1:0] La, Lal, Lb, Lbl;
    logic       err;

    int checks   = 0;
    int failures = 0;

    tl_state_seq #(.YELLOW_TICKS(3), .GREEN_MIN_TICKS(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .ns    (ns),
        .cs    (cs),
        .La    (La),
        .Lal   (Lal),
        .Lb    (Lb),
        .Lbl   (Lbl),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int m_cs, m_cnt, m_lim;
    bit m_err;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_cs    <= 0;
            m_cnt   <= 0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else if (int'(ns) != m_cs && int'(ns) != (m_cs + 1) % 8) begin
            m_err <= 1'b1;
        end else if (tick) begin
            m_lim = (m_cs % 2 == 1) ? 3 : 4;
            if (m_cnt == m_lim - 1 && int'(ns) != m_cs) begin
                m_cs  <= int'(ns);
                m_cnt <= 0;
            end else begin
                m_cnt <= (m_cnt + 1 > m_lim - 1) ? m_lim - 1 : m_cnt + 1;
            end
        end
    end

    // Lamp k (0=A straight,1=A left,2=B straight,3=B left) is owned by state pair k.
    function automatic int exp_lamp(input int s, input int k);
        if (s / 2 != k) return 2;
        return (s % 2 == 1) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            int lit;
            chk("cs", int'(cs), m_cs);
            chk("err", int'(err), int'(m_err));
            chk("La", int'(La), exp_lamp(m_cs, 0));
            chk("Lal", int'(Lal), exp_lamp(m_cs, 1));
            chk("Lb", int'(Lb), exp_lamp(m_cs, 2));
            chk("Lbl", int'(Lbl), exp_lamp(m_cs, 3));
            lit = int'(La != 2'b10) + int'(Lal != 2'b10) + int'(Lb != 2'b10) + int'(Lbl != 2'b10);
            chk("one_lit", int'(lit <= 1), 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [2:0] n, input logic t);
        ns   = n;
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cycle(input logic [2:0] n);
        step(n, 1'b1);
        step(n, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3'd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic advance_to(input logic [2:0] target);
        logic [2:0] n;
        int guard;
        guard = 0;
        while (cs != target && guard < 64) begin
            n = cs + 3'd1;
            tick_cycle(n);
            guard++;
        end
        chk("advance_to", int'(cs), int'(target));
    endtask

    initial begin
        logic [2:0] n, prev;
        int ticks_in, trans;
        reset = 1'b1;
        tick  = 1'b0;
        ns    = 3'd0;
        step(3'd0, 1'b0);
        step(3'd0, 1'b0);
        reset = 1'b0;

        // 1: reset state, hold S0
        chk("t1_cs", int'(cs), 0);
        chk("t1_La", int'(La), 0);
        chk("t1_Lal", int'(Lal), 2);
        chk("t1_Lb", int'(Lb), 2);
        chk("t1_Lbl", int'(Lbl), 2);
        chk("t1_err", int'(err), 0);
        for (int i = 0; i < 10; i++) tick_cycle(3'd0);
        chk("t1_hold_cs", int'(cs), 0);
        chk("t1_hold_err", int'(err), 0);

        // 2: green minimum then exact yellow
        do_reset();
        for (int i = 0; i < 3; i++) tick_cycle(3'd1);
        chk("t2_s0_after3", int'(cs), 0);
        tick_cycle(3'd1);
        chk("t2_s1_after4", int'(cs), 1);
        chk("t2_La_yellow", int'(La), 1);
        for (int i = 0; i < 2; i++) tick_cycle(3'd2);
        chk("t2_s1_after2", int'(cs), 1);
        tick_cycle(3'd2);
        chk("t2_s2_after3", int'(cs), 2);
        chk("t2_La_red", int'(La), 2);
        chk("t2_Lal_green", int'(Lal), 0);

        // 3: late request commits on the next tick; no tick, no change
        do_reset();
        for (int i = 0; i < 5; i++) tick_cycle(3'd0);
        step(3'd1, 1'b0);
        chk("t3_notick", int'(cs), 0);
        step(3'd1, 1'b1);
        chk("t3_commit", int'(cs), 1);

        // 4: full cycle with ns = cs+1
        do_reset();
        ticks_in = 0;
        trans    = 0;
        for (int i = 0; i < 100 && trans < 8; i++) begin
            prev = cs;
            n    = cs + 3'd1;
            tick_cycle(n);
            ticks_in++;
            if (cs != prev) begin
                chk("t4_order", int'(cs), (int'(prev) + 1) % 8);
                chk("t4_dwell", ticks_in, (prev[0]) ? 3 : 4);
                ticks_in = 0;
                trans++;
            end
        end
        chk("t4_transitions", trans, 8);
        chk("t4_wrap", int'(cs), 0);

        // 5: illegal request
        do_reset();
        advance_to(3'd2);
        step(3'd5, 1'b1);
        chk("t5_hold", int'(cs), 2);
        chk("t5_err", int'(err), 1);
        tick_cycle(3'd2);
        tick_cycle(3'd2);
        chk("t5_sticky", int'(err), 1);
        do_reset();
        chk("t5_clear", int'(err), 0);

        // 6: reset mid-dwell of S5
        do_reset();
        advance_to(3'd5);
        tick_cycle(3'd5);
        chk("t6_mid", int'(cs), 5);
        reset = 1'b1;
        step(3'd6, 1'b1);
        reset = 1'b0;
        chk("t6_cs", int'(cs), 0);
        chk("t6_err", int'(err), 0);
        chk("t6_La", int'(La), 0);
        for (int i = 0; i < 3; i++) tick_cycle(3'd1);
        chk("t6_cnt_cleared", int'(cs), 0);
        tick_cycle(3'd1);
        chk("t6_commit", int'(cs), 1);

        step(3'd1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
